// File: rtl/char_segment_projection.sv
// -----------------------------------------------------------------------------
// char_segment_projection
//
// Purpose:
//   Accumulates a per-column count of white pixels that fall inside the plate
//   box during a frame. During vertical blanking it scans those counts and
//   reports the left/right column of up to MAX_CHARS character segments. The
//   results go to the character recognition stage.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   per_frame_vsync/href/clken  frame / line / pixel valid of the binary stream
//   per_frame_Bit               binary pixel, 1 = white
//   plate_boarder_up/down/left/right, plate_exist_flag
//                               plate box (strict bounds) and its valid flag
//   char_left, char_right       segment i at [10*i+9:10*i], unused slots 0
//   char_num                    number of valid segments
//   char_overflow               more qualifying segments than slots
//   char_valid                  result strobe
//   busy                        high while accumulating or scanning
//
// Result handshake: char_valid is a one-cycle strobe with no back-pressure.
// In the cycle it is high, char_left/char_right/char_num/char_overflow carry
// the new frame result, and they hold that value until the next strobe.
//
// Configuration macro: CHAR_SEG_GAP_MERGE_EN
//   When defined, a single cold column inside an open segment that is
//   followed by a hot column does not split the segment.
// -----------------------------------------------------------------------------
module char_segment_projection #(
   parameter int IMG_WIDTH      = 640,
   parameter int MAX_CHARS      = 8,
   parameter int COL_THRESHOLD  = 2,
   parameter int MIN_CHAR_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     per_frame_vsync,
   input  logic                     per_frame_href,
   input  logic                     per_frame_clken,
   input  logic                     per_frame_Bit,
   input  logic [9:0]               plate_boarder_up,
   input  logic [9:0]               plate_boarder_down,
   input  logic [9:0]               plate_boarder_left,
   input  logic [9:0]               plate_boarder_right,
   input  logic                     plate_exist_flag,
   output logic [10*MAX_CHARS-1:0]  char_left,
   output logic [10*MAX_CHARS-1:0]  char_right,
   output logic [3:0]               char_num,
   output logic                     char_overflow,
   output logic                     char_valid,
   output logic                     busy
);

   localparam logic [9:0]  LAST_SC = 10'(IMG_WIDTH - 1);
   localparam logic [9:0]  IMG_W_L = 10'(IMG_WIDTH);
   localparam logic [9:0]  THRESH  = 10'(COL_THRESHOLD);
   localparam logic [10:0] MIN_W   = 11'(MIN_CHAR_WIDTH);
   localparam logic [3:0]  MAX_C   = 4'(MAX_CHARS);
   localparam logic [9:0]  SAT     = 10'd1023;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SCAN  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state, state_nx;

   // input stage and edge detection
   logic vsync_r, vsync_rr, href_r, href_rr, clken_r, bit_r;
   logic vsync_rise, vsync_fall, href_fall;

   // pixel position
   logic [9:0] x_cnt, y_cnt;

   // box and flag, latched at the end of each frame
   logic [9:0] lat_up, lat_down, lat_left, lat_right;
   logic       lat_flag;

   // projection memory
   logic [9:0] proj [IMG_WIDTH];
   logic [9:0] addr, rd, rd_inc;
   logic       acc_en;

   // scan state
   logic [9:0]  sc;
   logic        seg_open, gap_pend;
   logic [9:0]  seg_start;
   logic [3:0]  slot_cnt;
   logic        slot_ovf;
   logic [9:0]  seg_l [MAX_CHARS];
   logic [9:0]  seg_r [MAX_CHARS];

   // frame bookkeeping: the array is only trusted after one full scan
   logic proj_clean, frame_ok;

   // scan decision
   logic        col_in, hot, last_col;
   logic        open_nx, pend_nx, close_vld, qualify;
   logic [9:0]  start_nx, close_start, close_end;
   logic [10:0] seg_width;

   // ---------------------------------------------------------------- input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_r  <= 1'b0;
         vsync_rr <= 1'b0;
         href_r   <= 1'b0;
         href_rr  <= 1'b0;
         clken_r  <= 1'b0;
         bit_r    <= 1'b0;
      end else begin
         vsync_r  <= per_frame_vsync;
         vsync_rr <= vsync_r;
         href_r   <= per_frame_href;
         href_rr  <= href_r;
         clken_r  <= per_frame_clken;
         bit_r    <= per_frame_Bit;
      end
   end

   assign vsync_rise = vsync_r & ~vsync_rr;
   assign vsync_fall = ~vsync_r & vsync_rr;
   assign href_fall  = ~href_r & href_rr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (vsync_rise) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (href_fall) begin
         x_cnt <= '0;
         y_cnt <= y_cnt + 10'd1;
      end else if (clken_r) begin
         x_cnt <= x_cnt + 10'd1;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // A vsync rise seen in SCAN or DONE is simply not looked at, so that frame
   // is skipped and the next rise seen in IDLE starts a new one.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (vsync_rise) state_nx = S_ACCUM;
         S_ACCUM: if (vsync_fall) state_nx = S_SCAN;
         S_SCAN:  if (sc == LAST_SC) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state == S_ACCUM) || (state == S_SCAN);

   // ---------------------------------------------------------------- memory
   // One read port shared by accumulation (x) and scan (sc); the read feeds
   // a same-cycle write, so increment and clear are both single-cycle.
   assign addr   = (state == S_SCAN) ? sc : x_cnt;
   assign rd     = proj[addr];
   assign rd_inc = (rd == SAT) ? SAT : rd + 10'd1;

   assign acc_en = (state == S_ACCUM) && clken_r && bit_r && lat_flag &&
                   (lat_up < y_cnt) && (y_cnt < lat_down) &&
                   (lat_left < x_cnt) && (x_cnt < lat_right) &&
                   (x_cnt < IMG_W_L);

   // No reset: contents are made valid by the first full scan instead.
   always_ff @(posedge clk) begin
      if (acc_en)                proj[x_cnt] <= rd_inc;
      else if (state == S_SCAN)  proj[sc]    <= '0;
   end

   // ---------------------------------------------------------------- scan
   assign col_in   = lat_flag && (sc > lat_left) && (sc < lat_right);
   assign hot      = col_in && (rd >= THRESH);
   assign last_col = (({1'b0, sc} + 11'd1) == {1'b0, lat_right});

   always_comb begin
      open_nx     = seg_open;
      pend_nx     = gap_pend;
      start_nx    = seg_start;
      close_vld   = 1'b0;
      close_start = seg_start;
      close_end   = sc;
      if (col_in) begin
         if (hot) begin
            pend_nx = 1'b0;
            if (!seg_open) begin
               open_nx     = 1'b1;
               start_nx    = sc;
               close_start = sc;
            end
            // the box edge closes an open segment on its own column
            if (last_col) begin
               open_nx   = 1'b0;
               close_vld = 1'b1;
               close_end = sc;
            end
         end else if (seg_open) begin
`ifdef CHAR_SEG_GAP_MERGE_EN
            // gap_pend remembers one cold column; it is only forgiven if the
            // next column is hot, otherwise the segment ended before the gap
            if (gap_pend) begin
               open_nx   = 1'b0;
               pend_nx   = 1'b0;
               close_vld = 1'b1;
               close_end = sc - 10'd2;
            end else if (!last_col) begin
               pend_nx = 1'b1;
            end else begin
               open_nx   = 1'b0;
               close_vld = 1'b1;
               close_end = sc - 10'd1;
            end
`else
            open_nx   = 1'b0;
            close_vld = 1'b1;
            close_end = sc - 10'd1;
`endif
         end
      end
   end

   assign seg_width = {1'b0, close_end} - {1'b0, close_start} + 11'd1;
   assign qualify   = close_vld && (seg_width >= MIN_W);

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sc            <= '0;
         lat_up        <= '0;
         lat_down      <= '0;
         lat_left      <= '0;
         lat_right     <= '0;
         lat_flag      <= 1'b0;
         seg_open      <= 1'b0;
         gap_pend      <= 1'b0;
         seg_start     <= '0;
         slot_cnt      <= '0;
         slot_ovf      <= 1'b0;
         proj_clean    <= 1'b0;
         frame_ok      <= 1'b0;
         char_left     <= '0;
         char_right    <= '0;
         char_num      <= '0;
         char_overflow <= 1'b0;
         char_valid    <= 1'b0;
         for (int i = 0; i < MAX_CHARS; i++) begin
            seg_l[i] <= '0;
            seg_r[i] <= '0;
         end
      end else begin
         char_valid <= 1'b0;
         case (state)
            S_ACCUM: begin
               if (vsync_fall) begin
                  lat_up    <= plate_boarder_up;
                  lat_down  <= plate_boarder_down;
                  lat_left  <= plate_boarder_left;
                  lat_right <= plate_boarder_right;
                  lat_flag  <= plate_exist_flag;
                  sc        <= '0;
                  seg_open  <= 1'b0;
                  gap_pend  <= 1'b0;
                  slot_cnt  <= '0;
                  slot_ovf  <= 1'b0;
                  frame_ok  <= proj_clean;
                  for (int i = 0; i < MAX_CHARS; i++) begin
                     seg_l[i] <= '0;
                     seg_r[i] <= '0;
                  end
               end
            end
            S_SCAN: begin
               sc        <= (sc == LAST_SC) ? '0 : sc + 10'd1;
               seg_open  <= open_nx;
               gap_pend  <= pend_nx;
               seg_start <= start_nx;
               if (qualify) begin
                  if (slot_cnt < MAX_C) begin
                     for (int i = 0; i < MAX_CHARS; i++) begin
                        if (4'(i) == slot_cnt) begin
                           seg_l[i] <= close_start;
                           seg_r[i] <= close_end;
                        end
                     end
                     slot_cnt <= slot_cnt + 4'd1;
                  end else begin
                     slot_ovf <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               proj_clean <= 1'b1;
               // a frame accumulated on top of stale counts is dropped
               if (frame_ok) begin
                  for (int i = 0; i < MAX_CHARS; i++) begin
                     char_left[10*i +: 10]  <= seg_l[i];
                     char_right[10*i +: 10] <= seg_r[i];
                  end
                  char_num      <= slot_cnt;
                  char_overflow <= slot_ovf;
                  char_valid    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_char_segment_projection.sv
// -----------------------------------------------------------------------------
// tb_char_segment_projection
//
// Drives whole binary frames (one column pattern repeated on selected rows)
// into char_segment_projection and compares each frame result against a
// column-count reference computed from the picture description.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_char_segment_projection;

   localparam int W    = 640;
   localparam int MC   = 8;
   localparam int TH   = 2;
   localparam int MINW = 3;
   localparam int LAT  = W + 3;   // negedges from driving vsync low to strobe

   logic              clk = 1'b0;
   logic              rst_n;
   logic              vsync, href, clken, pix;
   logic [9:0]        p_up, p_down, p_left, p_right;
   logic              p_flag;
   logic [10*MC-1:0]  char_left, char_right;
   logic [3:0]        char_num;
   logic              char_overflow, char_valid, busy;

   always #5 clk = ~clk;

   char_segment_projection #(
      .IMG_WIDTH(W), .MAX_CHARS(MC), .COL_THRESHOLD(TH), .MIN_CHAR_WIDTH(MINW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .per_frame_vsync(vsync), .per_frame_href(href),
      .per_frame_clken(clken), .per_frame_Bit(pix),
      .plate_boarder_up(p_up), .plate_boarder_down(p_down),
      .plate_boarder_left(p_left), .plate_boarder_right(p_right),
      .plate_exist_flag(p_flag),
      .char_left(char_left), .char_right(char_right), .char_num(char_num),
      .char_overflow(char_overflow), .char_valid(char_valid), .busy(busy)
   );

   int n_chk = 0;
   int n_bad = 0;

   // picture of the current frame
   bit pat [W];
   bit row_on [64];
   int max_row;
   int b_up, b_down, b_left, b_right;
   bit b_flag;

   // box the DUT uses while accumulating (latched at the previous frame end)
   int a_up, a_down, a_left, a_right;
   bit a_flag;
   bit exp_clean;

   // expected held outputs and the reference result of the current frame
   logic [10*MC-1:0] cur_left, cur_right, m_left, m_right;
   logic [3:0]       cur_num, m_num;
   logic             cur_ovf, m_ovf;
   int               m_cnt [W];
   bit               m_hot [W];
   bit               m_fill [W];

   task automatic check_val(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_pic();
      for (int i = 0; i < W; i++) pat[i] = 1'b0;
      for (int i = 0; i < 64; i++) row_on[i] = 1'b0;
      max_row = 0;
   endtask

   task automatic set_cols(input int lo, input int hi);
      for (int c = lo; c <= hi; c++) pat[c] = 1'b1;
   endtask

   task automatic set_rows(input int lo, input int hi);
      for (int r = lo; r <= hi; r++) row_on[r] = 1'b1;
      if (hi > max_row) max_row = hi;
   endtask

   task automatic set_box(input int l, input int r, input int u, input int d,
                          input bit f);
      b_left = l; b_right = r; b_up = u; b_down = d; b_flag = f;
      p_left = 10'(l); p_right = 10'(r); p_up = 10'(u); p_down = 10'(d);
      p_flag = f;
   endtask

   // Reference: every drawn row carries the same column pattern, so a column's
   // count is the number of drawn rows inside the accumulation box.
   task automatic add_seg(input int s, input int e);
      if (e - s + 1 >= MINW) begin
         if (int'(m_num) < MC) begin
            m_left[10*m_num +: 10]  = 10'(s);
            m_right[10*m_num +: 10] = 10'(e);
            m_num = m_num + 4'd1;
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic model_frame();
      int rows_in;
      int start;
      bit in_run;
      m_left = '0; m_right = '0; m_num = '0; m_ovf = 1'b0;
      rows_in = 0;
      for (int r = 0; r <= max_row; r++)
         if (row_on[r] && r > a_up && r < a_down) rows_in++;
      for (int c = 0; c < W; c++) begin
         m_cnt[c] = (a_flag && pat[c] && c > a_left && c < a_right) ? rows_in : 0;
         m_hot[c] = b_flag && c > b_left && c < b_right && m_cnt[c] >= TH;
         m_fill[c] = m_hot[c];
      end
`ifdef CHAR_SEG_GAP_MERGE_EN
      for (int c = 1; c < W - 1; c++)
         if (!m_hot[c] && m_hot[c-1] && m_hot[c+1]) m_fill[c] = 1'b1;
`endif
      in_run = 1'b0;
      start = 0;
      for (int c = b_left + 1; c < b_right && c < W; c++) begin
         if (m_fill[c]) begin
            if (!in_run) begin in_run = 1'b1; start = c; end
            if (c == b_right - 1) begin add_seg(start, c); in_run = 1'b0; end
         end else if (in_run) begin
            add_seg(start, c - 1);
            in_run = 1'b0;
         end
      end
   endtask

   task automatic send_frame();
      int len;
      len = 1;
      for (int c = 0; c < W; c++) if (pat[c]) len = c + 1;
      @(negedge clk); vsync = 1'b1;
      repeat (3) @(negedge clk);
      for (int r = 0; r <= max_row; r++) begin
         if (row_on[r]) begin
            for (int c = 0; c < len; c++) begin
               @(negedge clk); href = 1'b1; clken = 1'b1; pix = pat[c];
            end
         end else begin
            @(negedge clk); href = 1'b1; clken = 1'b0; pix = 1'b0;
         end
         @(negedge clk); href = 1'b0; clken = 1'b0; pix = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, "_num"},   char_num,      cur_num);
      check_val({tag, "_ovf"},   char_overflow, cur_ovf);
      check_val({tag, "_left"},  char_left,     cur_left);
      check_val({tag, "_right"}, char_right,    cur_right);
   endtask

   // rst_at > 0 pulses rst_n for one cycle that many negedges into the scan
   task automatic run_frame(input string tag, input int rst_at);
      bit ok;
      int first_k, pulses;
      logic busy_mid;
      ok = exp_clean && (rst_at == 0);
      model_frame();
      send_frame();
      @(negedge clk); vsync = 1'b0;
      first_k = -1; pulses = 0; busy_mid = 1'b0;
      for (int k = 1; k <= LAT + 60; k++) begin
         @(negedge clk);
         if (k == 10) busy_mid = busy;
         if (rst_at > 0 && k == rst_at) rst_n = 1'b0;
         if (rst_at > 0 && k == rst_at + 1) begin
            check_val({tag, "_rst_valid"}, char_valid, 1'b0);
            check_val({tag, "_rst_busy"},  busy,       1'b0);
            cur_left = '0; cur_right = '0; cur_num = '0; cur_ovf = 1'b0;
            check_outputs({tag, "_rst"});
            rst_n = 1'b1;
         end
         if (char_valid) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
      end
      check_val({tag, "_busy_scan"}, busy_mid, 1'b1);
      check_val({tag, "_busy_end"},  busy,     1'b0);
      if (ok) begin
         check_val({tag, "_latency"}, first_k, LAT);
         check_val({tag, "_pulses"},  pulses,  1);
         cur_left = m_left; cur_right = m_right; cur_num = m_num; cur_ovf = m_ovf;
      end else begin
         check_val({tag, "_no_valid"}, pulses, 0);
      end
      check_outputs(tag);
      if (rst_at > 0) begin
         a_up = 0; a_down = 0; a_left = 0; a_right = 0; a_flag = 1'b0;
         exp_clean = 1'b0;
      end else begin
         a_up = b_up; a_down = b_down; a_left = b_left; a_right = b_right;
         a_flag = b_flag;
         exp_clean = 1'b1;
      end
   endtask

   task automatic random_frame(input int idx);
      int l, r, c, len;
      bit h;
      l = $urandom_range(0, 150);
      r = l + $urandom_range(10, 200);
      set_box(l, r, 2, 9, ($urandom_range(0, 4) != 0));
      clear_pic();
      for (int i = 0; i <= 10; i++) row_on[i] = ($urandom_range(0, 9) < 6);
      max_row = 10;
      c = (l > 2) ? l - 2 : 0;
      h = 1'($urandom_range(0, 1));
      while (c <= r + 2 && c < W) begin
         len = h ? $urandom_range(1, 7) : $urandom_range(1, 3);
         for (int j = 0; j < len && c < W; j++) begin
            pat[c] = h;
            c++;
         end
         h = !h;
      end
      run_frame($sformatf("rnd%0d", idx), 0);
   endtask

   initial begin
      rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; pix = 1'b0;
      set_box(100, 300, 50, 100, 1'b1);
      a_up = 0; a_down = 0; a_left = 0; a_right = 0; a_flag = 1'b0;
      exp_clean = 1'b0;
      cur_left = '0; cur_right = '0; cur_num = '0; cur_ovf = 1'b0;
      repeat (4) @(negedge clk);
      check_val("reset_valid", char_valid, 1'b0);
      check_val("reset_busy",  busy,       1'b0);
      check_outputs("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // two 10-wide characters; the first frame after reset is discarded
      clear_pic(); set_cols(120, 129); set_cols(150, 159); set_rows(51, 53);
      run_frame("discard0", 0);
      run_frame("t1", 0);
      check_val("t1_const_num",   char_num,          2);
      check_val("t1_const_left",  char_left[19:0],   {10'd150, 10'd120});
      check_val("t1_const_right", char_right[19:0],  {10'd159, 10'd129});

      // single column and a 2-wide block are both too narrow
      clear_pic(); set_cols(200, 200); set_cols(210, 211); set_rows(51, 53);
      run_frame("t2", 0);
      check_val("t2_const_num", char_num, 0);

      // ten 5-wide blocks: eight stored, overflow flagged
      clear_pic();
      for (int i = 0; i < 10; i++) set_cols(110 + 10*i, 114 + 10*i);
      set_rows(51, 53);
      run_frame("t3", 0);
      check_val("t3_const_num",    char_num,           8);
      check_val("t3_const_ovf",    char_overflow,      1'b1);
      check_val("t3_const_slot7l", char_left[79:70],   180);
      check_val("t3_const_slot7r", char_right[79:70],  184);

      // white only outside the box, then an all-black frame
      clear_pic(); set_cols(50, 50); set_rows(10, 40);
      run_frame("t4a", 0);
      clear_pic();
      run_frame("t4b", 0);
      check_val("t4b_const_num", char_num, 0);

      // one cold column inside a block
      clear_pic(); set_cols(120, 124); set_cols(126, 129); set_rows(51, 53);
      run_frame("t5", 0);
`ifdef CHAR_SEG_GAP_MERGE_EN
      check_val("t5_const_num",   char_num,         1);
      check_val("t5_const_right", char_right[9:0],  129);
`else
      check_val("t5_const_num",   char_num,         2);
      check_val("t5_const_right", char_right[9:0],  124);
      check_val("t5_const_left1", char_left[19:10], 126);
`endif

      // reset in the middle of a scan, then one discarded frame
      clear_pic(); set_cols(120, 129); set_cols(150, 159); set_rows(51, 53);
      run_frame("pre_rst", 0);
      run_frame("rst_mid", 100);
      clear_pic(); set_cols(120, 124); set_cols(290, 299); set_rows(51, 53);
      run_frame("post_rst_discard", 0);
      run_frame("post_rst", 0);
      check_val("post_rst_const_num",    char_num,          2);
      check_val("post_rst_const_right1", char_right[19:10], 299);

      for (int i = 0; i < 7; i++) random_frame(i);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/char_segment_projection.md
Name: char_segment_projection

Overview:
- Consumer of the binary pixel stream produced by the plate binarization stage.
- Accumulates a vertical (per-column) projection of white pixels inside the plate box during a frame.
- During vertical blanking, scans the projection and reports left/right column boundaries of up to MAX_CHARS character segments.
- Feeds the character recognition/template-matching stage.

Parameters:
- IMG_WIDTH, 640: active pixels per line; projection array depth.
- MAX_CHARS, 8: max segments reported.
- COL_THRESHOLD, 2: min white-pixel count for a column to count as "character".
- MIN_CHAR_WIDTH, 3: min segment width in columns; narrower segments are discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- per_frame_vsync  in  1  frame valid, high for whole active frame
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel valid
- per_frame_Bit  in  1  binary pixel, 1 = white
- plate_boarder_up/down/left/right  in  10 each  plate box
- plate_exist_flag  in  1  plate box valid
- char_left  out  10*MAX_CHARS  segment left columns, segment i at [10*i+9:10*i]
- char_right  out  10*MAX_CHARS  segment right columns, same packing
- char_num  out  4  number of valid segments, 0..MAX_CHARS
- char_overflow  out  1  more than MAX_CHARS qualifying segments found
- char_valid  out  1  one-cycle pulse when the outputs update
- busy  out  1  high in ACCUM or SCAN

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, FSM to IDLE, scan counter 0. Projection array is not cleared by reset.
  - An array must be cleared once after power-up. The first SCAN clears it, so the first frame after reset is discarded: no char_valid for it.
- Stream inputs are registered once. Edges are detected on registered versus twice-registered samples.
- Pixel position counters:
  - x increments on each registered clken.
  - x resets to 0 and y increments on the href falling edge.
  - x and y reset on the vsync rising edge.
- Box test uses strict inequalities: up < y < down and left < x < right.
- FSM:
  - IDLE: on vsync rising edge, go to ACCUM.
  - ACCUM: on each registered clken with Bit = 1, in-box position, x < IMG_WIDTH, and latched plate_exist_flag = 1, increment proj[x]. Increment is read-modify-write in one cycle and saturates at 1023.
    - On vsync falling edge, latch the box and plate_exist_flag, then go to SCAN.
  - SCAN: one column per cycle, sc = 0..IMG_WIDTH-1.
    - Read proj[sc], then write 0 to it (clears the array for the next frame).
    - Evaluate only columns left < sc < right.
    - A column is "hot" if its count >= COL_THRESHOLD.
    - Segment open: first hot column; record its start.
    - Segment close: first non-hot column, or sc = right-1 while open (end = sc in that case, otherwise end = sc-1).
    - On close, the segment qualifies if (end - start + 1) >= MIN_CHAR_WIDTH.
      - If fewer than MAX_CHARS are stored, store it in the next slot.
      - Otherwise set the overflow bit.
    - Latched plate_exist_flag = 0: clear proj only, store no segments.
    - After sc = IMG_WIDTH-1, go to DONE.
  - DONE (one cycle):
    - Transfer stored segments, count and overflow to the outputs; unused slots are 0.
    - Pulse char_valid.
    - Go to IDLE.
- Latency: char_valid is high exactly IMG_WIDTH+2 clk cycles after the first cycle the registered vsync is low.
- Outputs hold their values until the next DONE.
- A vsync rising edge during SCAN or DONE is ignored: that frame is not accumulated and FSM returns to IDLE. The next frame is processed normally.
- Segments are reported in ascending column order.
- Reset during ACCUM/SCAN aborts the frame. The stale array is handled as for power-up: the next frame is discarded.

Optional Feature:
- Macro CHAR_SEG_GAP_MERGE_EN.
- Defined: while a segment is open, a single non-hot column followed by a hot column does not close the segment. This handles broken strokes.
  - Requires a one-column lookahead register; segment edge values are unchanged.
  - The gap column counts toward width.
- Undefined: any non-hot column closes the segment.

Test Plan:
- Box 100/300/50/100, flag = 1; white columns 120..129 and 150..159 on rows 51..99 -> char_num = 2, char_left = {150,120}, char_right = {159,129}, char_overflow = 0, one char_valid at IMG_WIDTH+2 after vsync falls.
- Single white column x = 200 plus width-2 block 210..211 -> both discarded, char_num = 0, char_valid still pulses.
- Ten 5-wide blocks spaced 10 apart from x = 110 -> char_num = 8, slot 7 = 180..184, char_overflow = 1.
- White only at x = 50 and rows 10..40 (outside box), then next frame all black -> char_num = 0 both frames; the second frame proves clearing.
- Hot columns 120..129 except 125 cold -> with CHAR_SEG_GAP_MERGE_EN: one segment 120..129; without: 120..124 and 126..129.
- rst_n low for 1 cycle mid-SCAN -> all outputs 0 next cycle, no char_valid for that frame. Next frame discarded, following frame reports correct segments. Also a block running to x = 299 closes with right = 299.
